// File: rtl/scan_pkg.sv
// Shared encodings for the decoder scan sequencer: FSM states and scan direction.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEEK  = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/scan_dwell_timer.sv
// Per-channel dwell down-counter: load sets the count, then it decrements to a saturated zero.
module scan_dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Walks a binary select index over enabled channels, holding each for dwell+1 cycles,
// to drive an external SEL_W-to-2**SEL_W one-hot decoder.
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic                    dir,
  input  logic [(1<<SEL_W)-1:0]   chan_mask,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [SEL_W-1:0]        sel,
  output logic                    active,
  output logic                    step,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned N = 1 << SEL_W;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               active_q, step_q, busy_q, done_q;
  logic [N-1:0]       mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q, cont_q;

  logic               at_end_c, hit_c, tmr_load_c, tmr_zero;
  logic [SEL_W-1:0]   sel_next_c;

  // Next index wraps naturally on SEL_W bits; the end boundary depends on direction.
  assign sel_next_c = (dir_q == DIR_UP) ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
  assign at_end_c   = (dir_q == DIR_UP) ? (sel_q == SEL_W'(N - 1)) : (sel_q == '0);
  assign hit_c      = mask_q[sel_q];
  assign tmr_load_c = (state_q == S_SEEK) && hit_c && !stop;

  scan_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load_c),
    .value (dwell_q),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      dwell_q  <= '0;
      dir_q    <= DIR_UP;
      cont_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (stop) begin
        state_q  <= S_IDLE;
        active_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              mask_q  <= chan_mask;
              dwell_q <= dwell;
              dir_q   <= dir;
              cont_q  <= continuous;
              if (chan_mask == '0) begin
                done_q <= 1'b1;
              end else begin
                sel_q   <= (dir == DIR_DN) ? SEL_W'(N - 1) : '0;
                state_q <= S_SEEK;
                busy_q  <= 1'b1;
              end
            end
          end
          S_SEEK: begin
            if (hit_c) begin
              state_q  <= S_DWELL;
              active_q <= 1'b1;
              step_q   <= 1'b1;
            end else if (at_end_c && !cont_q) begin
              // Single pass ran off the end with no channel left to present.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sel_q <= sel_next_c;
            end
          end
          S_DWELL: begin
            if (tmr_zero) begin
              active_q <= 1'b0;
              if (at_end_c && !cont_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                sel_q   <= sel_next_c;
                state_q <= S_SEEK;
              end
            end
          end
          default: begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel    = sel_q;
  assign active = active_q;
  assign step   = step_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
